// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one off-chip memory port between the I-cache and D-cache miss /
// write-back engines. One requester is granted at a time and the grant is
// held until the memory returns its completion pulse. The D-cache wins by
// default; a small counter of D grants taken while an I read was waiting
// forces the I-cache through after MAX_WAIT losses.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   i_read / i_addr        : I-cache line read request (level, held until i_ready)
//   i_ready / i_rdata      : I-cache completion pulse and read data
//   d_read / d_write       : D-cache line read / write-back request (level)
//   d_addr / d_wdata       : D-cache address and write-back data
//   d_ready / d_rdata      : D-cache completion pulse and read data
//   mem_read / mem_write   : registered memory strobes, held until mem_ready
//   mem_addr / mem_wdata   : registered memory address and write data
//   mem_ready / mem_rdata  : memory completion pulse and read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 128,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t              state_q,     state_d;
    logic [3:0]          wait_cnt_q,  wait_cnt_d;
    logic                mem_read_q,  mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                d_req;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_req       = d_read | d_write;

        case (state_q)
            IDLE: begin
                if (d_req && i_read && (wait_cnt_q == MAX_WAIT_C)) begin
                    // I has lost MAX_WAIT times in a row: it takes this slot.
                    state_d     = GRANT_I;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = i_addr;
                    wait_cnt_d  = 4'd0;
                end else if (d_req) begin
                    // A combined read+write request issues the write-back first;
                    // the D-cache re-requests the read afterwards.
                    state_d     = GRANT_D;
                    mem_read_d  = d_read & ~d_write;
                    mem_write_d = d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (i_read && (wait_cnt_q < MAX_WAIT_C)) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else if (i_read) begin
                    state_d     = GRANT_I;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = i_addr;
                    wait_cnt_d  = 4'd0;
                end
            end
            GRANT_I, GRANT_D: begin
                // Strobes and address stay frozen until memory completes.
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                // One dead cycle so the finished requester can drop its level
                // request before the next arbitration sees it.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Completion is forwarded with no added latency, only to the granted side.
    assign i_ready = mem_ready & (state_q == GRANT_I);
    assign d_ready = mem_ready & (state_q == GRANT_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter: directed reset / solo-read / write-back /
// mid-transaction reset cases, a starvation-bound scenario, then concurrent
// randomized I and D cache traffic against a randomly-delayed memory model.
// Expected read data is queued when a request is issued and popped by a
// separate monitor on each ready pulse; a second monitor predicts each
// grant from the arbitration rules and checks the memory-side strobes.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Untouched memory lines hold a value derived from their address.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {4{4'hC, a}};
    endfunction

    logic [DW-1:0] phys[logic [AW-1:0]];     // memory contents seen by the responder
    logic [DW-1:0] ref_mem[logic [AW-1:0]];  // reference contents in issue order

    typedef struct {
        logic          is_write;
        logic [DW-1:0] data;
    } exp_t;
    exp_t          d_exp[$];
    logic [DW-1:0] i_exp[$];
    int            grant_log[$];   // 1 = I won, 0 = D won

    bit resp_en = 1'b0;
    bit mon_en  = 1'b0;

    // ---------------- memory responder ----------------
    bit resp_busy = 1'b0;
    int resp_cnt  = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (resp_en) begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                resp_busy = 1'b0;
            end else if (!(mem_read || mem_write)) begin
                resp_busy = 1'b0;
            end else begin
                if (!resp_busy) begin
                    resp_busy = 1'b1;
                    resp_cnt  = $urandom_range(0, 4);
                end
                if (resp_cnt == 0) begin
                    mem_ready = 1'b1;
                    if (mem_write) begin
                        phys[mem_addr] = mem_wdata;
                        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    end else begin
                        mem_rdata = phys.exists(mem_addr) ? phys[mem_addr] : init_val(mem_addr);
                    end
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    // ---------------- arbitration monitor ----------------
    // phase: 0 free, 1 decided (strobes due now), 2 granted, 3 release cycle
    int            phase    = 0;
    int            lost_cnt = 0;
    bit            win_i    = 1'b0;
    logic          exp_rd, exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          strobe, strobe_prev;
    logic          d_pend;
    initial forever begin
        @(negedge clk);
        if (!mon_en) begin
            phase       = 0;
            lost_cnt    = 0;
            strobe_prev = 1'b0;
        end else begin
            strobe = mem_read | mem_write;
            if (phase == 1) begin
                check("grant_mem_read",  DW'(mem_read),  DW'(exp_rd));
                check("grant_mem_write", DW'(mem_write), DW'(exp_wr));
                check("grant_mem_addr",  DW'(mem_addr),  DW'(exp_addr));
                if (!win_i) check("grant_mem_wdata", mem_wdata, exp_wdata);
                phase = 2;
            end else if (strobe && !strobe_prev) begin
                check("spurious_grant", DW'(strobe), DW'(0));
            end
            check("i_ready", DW'(i_ready), DW'(mem_ready && phase == 2 && win_i));
            check("d_ready", DW'(d_ready), DW'(mem_ready && phase == 2 && !win_i));
            if (phase == 2) begin
                check("strobe_hold", DW'({mem_read, mem_write, mem_addr}), DW'({exp_rd, exp_wr, exp_addr}));
                if (mem_ready) phase = 3;
            end else if (phase == 3) begin
                check("release_quiet", DW'(strobe), DW'(0));
                phase = 0;
            end else if (phase == 0) begin
                d_pend = d_read | d_write;
                if (d_pend || i_read) begin
                    if (d_pend && i_read && lost_cnt == MW) begin
                        win_i = 1'b1;
                    end else if (d_pend) begin
                        win_i = 1'b0;
                        if (i_read && lost_cnt < MW) lost_cnt++;
                    end else begin
                        win_i = 1'b1;
                    end
                    if (win_i) begin
                        lost_cnt = 0;
                        exp_rd   = 1'b1;
                        exp_wr   = 1'b0;
                        exp_addr = i_addr;
                    end else begin
                        exp_rd    = d_read & ~d_write;
                        exp_wr    = d_write;
                        exp_addr  = d_addr;
                        exp_wdata = d_wdata;
                    end
                    grant_log.push_back(win_i ? 1 : 0);
                    phase = 1;
                end
            end
            strobe_prev = strobe;
        end
    end

    // ---------------- data scoreboard monitor ----------------
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (i_ready) begin
                if (i_exp.size() == 0) check("i_ready_unexpected", DW'(1), DW'(0));
                else check("i_rdata", i_rdata, i_exp.pop_front());
            end
            if (d_ready) begin
                if (d_exp.size() == 0) begin
                    check("d_ready_unexpected", DW'(1), DW'(0));
                end else begin
                    exp_t e;
                    e = d_exp.pop_front();
                    if (!e.is_write) check("d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    // ---------------- cache-side drivers ----------------
    task automatic d_txn(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        exp_t e;
        int   n;
        e.is_write = wr;
        e.data     = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        if (wr) ref_mem[a] = wd;
        d_exp.push_back(e);
        d_read  = rd;
        d_write = wr;
        d_addr  = a;
        d_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ready && n < 300);
        check("d_handshake", DW'(d_ready), DW'(1));
        @(posedge clk);
        #1;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic i_txn(input logic [AW-1:0] a);
        int n;
        i_exp.push_back(ref_mem.exists(a) ? ref_mem[a] : init_val(a));
        i_read = 1'b1;
        i_addr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ready && n < 300);
        check("i_handshake", DW'(i_ready), DW'(1));
        @(posedge clk);
        #1;
        i_read = 1'b0;
    endtask

    task automatic idle_gap(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- main sequence ----------------
    logic [DW-1:0] rd_pat;
    logic [DW-1:0] wb_pat;
    initial begin
        rd_pat = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        wb_pat = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
        rst = 1'b1; i_read = 1'b1; i_addr = 28'h0000123;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset held with a pending I read: nothing is granted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read",  DW'(mem_read),  DW'(0));
        check("rst_mem_write", DW'(mem_write), DW'(0));
        check("rst_mem_addr",  DW'(mem_addr),  DW'(0));
        check("rst_i_ready",   DW'(i_ready),   DW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_before_grant", DW'(mem_read), DW'(0));
        @(negedge clk);
        check("solo_mem_read",  DW'(mem_read),  DW'(1));
        check("solo_mem_write", DW'(mem_write), DW'(0));
        check("solo_mem_addr",  DW'(mem_addr),  DW'(28'h0000123));

        // Solo I read: memory answers five cycles into the grant.
        repeat (4) begin
            @(negedge clk);
            check("solo_wait_i_ready", DW'(i_ready), DW'(0));
        end
        @(posedge clk);
        #1 mem_ready = 1'b1; mem_rdata = rd_pat;
        @(negedge clk);
        check("solo_i_ready", DW'(i_ready), DW'(1));
        check("solo_i_rdata", i_rdata, rd_pat);
        check("solo_d_ready", DW'(d_ready), DW'(0));
        // mem_ready left high into the release cycle must not be forwarded.
        @(posedge clk);
        #1 i_read = 1'b0;
        @(negedge clk);
        check("release_i_ready",  DW'(i_ready),  DW'(0));
        check("release_d_ready",  DW'(d_ready),  DW'(0));
        check("release_mem_read", DW'(mem_read), DW'(0));
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check("idle_mem_read", DW'(mem_read), DW'(0));

        // D write-back with a read also pending: write wins.
        d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000040; d_wdata = wb_pat;
        @(negedge clk);
        check("wb_mem_write", DW'(mem_write), DW'(1));
        check("wb_mem_read",  DW'(mem_read),  DW'(0));
        check("wb_mem_addr",  DW'(mem_addr),  DW'(28'h0000040));
        check("wb_mem_wdata", mem_wdata, wb_pat);
        check("wb_no_ready",  DW'(d_ready),   DW'(0));

        // Reset mid-transaction aborts; a late mem_ready produces nothing.
        rst = 1'b1; d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        check("abort_mem_write", DW'(mem_write), DW'(0));
        check("abort_mem_read",  DW'(mem_read),  DW'(0));
        check("abort_mem_wdata", mem_wdata, DW'(0));
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        check("late_d_ready", DW'(d_ready), DW'(0));
        check("late_i_ready", DW'(i_ready), DW'(0));
        @(negedge clk);
        check("late_d_ready2", DW'(d_ready), DW'(0));
        check("late_no_grant", DW'(mem_read | mem_write), DW'(0));
        mem_ready = 1'b0;

        // Write-back completes normally: d_ready follows mem_ready.
        d_read = 1'b1; d_write = 1'b1;
        @(negedge clk);
        check("wb2_mem_write", DW'(mem_write), DW'(1));
        mem_ready = 1'b1; mem_rdata = rd_pat;
        #1;
        check("wb2_d_ready", DW'(d_ready), DW'(1));
        check("wb2_i_ready", DW'(i_ready), DW'(0));
        @(posedge clk);
        #1 mem_ready = 1'b0; d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        check("wb2_release", DW'(mem_write), DW'(0));

        // Clean reset, then hand over to the responder and monitors.
        @(posedge clk);
        #1 rst = 1'b1;
        idle_gap(2);
        rst = 1'b0; resp_en = 1'b1; mon_en = 1'b1;
        grant_log.delete();

        // Starvation bound: D re-requests back to back while I waits.
        fork
            begin
                for (int k = 0; k < 6; k++) d_txn(1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
            end
            begin
                i_txn({1'b1, 27'($urandom)});
            end
        join
        check("starve_grants", DW'(grant_log.size()), DW'(7));
        for (int k = 0; k < 7 && k < grant_log.size(); k++)
            check($sformatf("starve_order_%0d", k), DW'(grant_log[k]), DW'(k == MW));

        // Randomized concurrent traffic.
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int op;
                    idle_gap($urandom_range(0, 3));
                    op = $urandom_range(0, 2);
                    d_txn(op != 1, op != 0, AW'($urandom_range(0, 15)),
                          {$urandom, $urandom, $urandom, $urandom});
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    idle_gap($urandom_range(0, 3));
                    i_txn({1'b1, 27'($urandom)});
                end
            end
        join
        idle_gap(5);
        check("d_queue_drained", DW'(d_exp.size()), DW'(0));
        check("i_queue_drained", DW'(i_exp.size()), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache and D-cache miss/write-back engines.
- Sits between the two cache controllers and the memory model. Grants one requester at a time and holds the grant until the transaction finishes.
- D-cache has default priority. A bounded-wait counter prevents I-cache starvation.
- Cache-side interfaces are level-held request / single-cycle ready, identical to the memory-side protocol. Each cache therefore connects unchanged.

Parameters:
ADDR_W, 28, block address width (word address / 4)
DATA_W, 128, cache line width
MAX_WAIT, 4, number of consecutive D grants an I request may lose before I is forced to win; legal range 1..15

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
i_read  input  1  I-cache line read request, held until i_ready
i_addr  input  ADDR_W  I-cache line address
i_ready  output  1  one-cycle completion pulse to I-cache
i_rdata  output  DATA_W  read data to I-cache, valid when i_ready
d_read  input  1  D-cache line read request, held until d_ready
d_write  input  1  D-cache line write-back request, held until d_ready
d_addr  input  ADDR_W  D-cache line address
d_wdata  input  DATA_W  D-cache write data
d_ready  output  1  one-cycle completion pulse to D-cache
d_rdata  output  DATA_W  read data to D-cache, valid when d_ready
mem_read  output  1  memory read strobe, held until mem_ready
mem_write  output  1  memory write strobe, held until mem_ready
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ready  input  1  memory completion pulse
mem_rdata  input  DATA_W  memory read data, valid with mem_ready

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Reset (rst=1 at clk edge) puts the FSM in IDLE and clears wait_cnt to 0.
- All registered outputs reset to 0: mem_read, mem_write, mem_addr, mem_wdata.
- i_ready and d_ready are combinational.
  - i_ready = mem_ready & (state==GRANT_I).
  - d_ready = mem_ready & (state==GRANT_D).
  - Both are 0 in IDLE and RELEASE regardless of mem_ready.
- i_rdata and d_rdata are direct copies of mem_rdata, with no muxing or latency.
- IDLE:
  - d_req = d_read | d_write.
  - If d_req and i_read and wait_cnt==MAX_WAIT, go to GRANT_I.
  - Otherwise, if d_req, go to GRANT_D; if i_read is also high, wait_cnt increments (saturating at MAX_WAIT).
  - Otherwise, if i_read, go to GRANT_I.
  - Otherwise stay in IDLE.
- Entering GRANT_I:
  - Register mem_read=1, mem_write=0, mem_addr=i_addr.
  - wait_cnt clears to 0.
- Entering GRANT_D:
  - Register mem_read=d_read, mem_write=d_write, mem_addr=d_addr, mem_wdata=d_wdata.
  - If d_read and d_write are both 1, mem_write wins and mem_read=0. The D-cache issues the write-back first.
- Latency:
  - Memory strobes rise one cycle after the request is sampled in IDLE.
  - Requester ready equals the memory ready pulse, with zero added latency.
- GRANT_x: the registered strobes and address are held stable (the request inputs are ignored) until mem_ready=1. Then:
  - clear mem_read and mem_write at that edge;
  - go to RELEASE.
- RELEASE:
  - Lasts exactly one cycle, then returns to IDLE. No grant is made in this cycle.
  - Guarantees the finished requester has dropped its level request before re-arbitration, so a stale request is not re-granted.
- Minimum spacing between transactions: IDLE→GRANT→(≥1 cycle)→RELEASE→IDLE, so a back-to-back grant needs ≥3 cycles.
- If mem_ready arrives in IDLE or RELEASE, it is ignored and no ready is forwarded.
- A requester's request dropped while not granted is simply lost; caches must hold requests, so this is a protocol violation.
- wait_cnt is 4 bits and counts only D grants taken while i_read was pending. It never wraps.
- A mid-transaction rst aborts the transaction: strobes drop to 0 at that edge and no ready is emitted. The caches are reset by the same rst.

Test Plan:
- Reset then idle: rst high 2 cycles with i_read=1 -> mem_read=0, i_ready=0. Release rst -> mem_read=1 and mem_addr=i_addr one cycle later.
- Solo I read: i_addr=0x0000123, memory responds mem_ready after 5 cycles with mem_rdata=0xDEAD…BEEF -> i_ready pulses 1 cycle with i_rdata equal to mem_rdata, d_ready=0, RELEASE then IDLE.
- Simultaneous requests: i_read=1 and d_read=1 in the same cycle -> GRANT_D first. After completion plus RELEASE, GRANT_I, provided d_req drops.
- Starvation bound: MAX_WAIT=4, d_read re-asserted immediately after every d_ready while i_read is held -> exactly 4 D grants, then I is granted, then wait_cnt=0.
- D write-back with read pending: d_write=1, d_read=1, d_addr=0x0000040, d_wdata=pattern -> mem_write=1, mem_read=0, mem_wdata=pattern. d_ready is asserted on mem_ready.
- Reset mid-transaction: rst asserted while in GRANT_D before mem_ready -> next cycle mem_write=0, mem_read=0, state IDLE. A late mem_ready produces no d_ready.
